// File: rtl/register_shift_reader.sv
// ============================================================================
// register_shift_reader
//
// Reader end of a parallel-load register. A WIDTH-bit word is captured through
// a valid/ready handshake and then sent out serially, LSB first, with an
// independent valid/ready handshake on every output bit.
//
// Optional feature (compile-time macro):
//   REGISTER_SHIFT_READER_PARITY_EN
//     Defined   : an even-parity bit (XOR of the captured word) follows the
//                 last data bit and carries sout_last instead of it.
//     Undefined : plain WIDTH-bit stream, no parity logic at all.
//
// Parameters:
//   WIDTH       word width in bits, must be >= 2
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous reset, active-low
//   in          in   parallel word offered by the producer
//   in_valid    in   producer offers `in`
//   in_ready    out  block can accept a word (only while idle)
//   sout        out  current serial bit
//   sout_valid  out  `sout` is valid
//   sout_ready  in   consumer takes `sout` on this clock edge
//   sout_last   out  current bit is the final bit of the word
//   busy        out  a word is being shifted out
// ============================================================================
module register_shift_reader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULTIMATE = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef REGISTER_SHIFT_READER_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t state;

  // Bit 0 of the word goes straight into the sout register at capture, so the
  // shift register only keeps the bits that are still waiting to be sent.
  logic [WIDTH-1:1] shift_reg;
  logic [CW-1:0]    count;

`ifdef REGISTER_SHIFT_READER_PARITY_EN
  logic parity_bit;
`endif

  // Single registered FSM: every output is a flop, so the first bit appears
  // one cycle after acceptance and nothing glitches on the serial side.
  // count saturates at LAST_IDX on the exit transition instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      count      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
`ifdef REGISTER_SHIFT_READER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shift_reg  <= in[WIDTH-1:1];
            count      <= '0;
            sout       <= in[0];
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
            state      <= SHIFT;
`ifdef REGISTER_SHIFT_READER_PARITY_EN
            parity_bit <= ^in;
`endif
          end
        end

        SHIFT: begin
          if (sout_valid && sout_ready) begin
            if (count == LAST_IDX) begin
`ifdef REGISTER_SHIFT_READER_PARITY_EN
              // Last data bit gone: present the parity bit as the final one.
              sout      <= parity_bit;
              sout_last <= 1'b1;
              state     <= PARITY;
`else
              sout       <= 1'b0;
              sout_valid <= 1'b0;
              sout_last  <= 1'b0;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              state      <= IDLE;
`endif
            end else begin
              sout      <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
              count     <= count + 1'b1;
`ifdef REGISTER_SHIFT_READER_PARITY_EN
              sout_last <= 1'b0;
`else
              sout_last <= (count == PENULTIMATE);
`endif
            end
          end
        end

`ifdef REGISTER_SHIFT_READER_PARITY_EN
        PARITY: begin
          if (sout_valid && sout_ready) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_shift_reader.sv
// ============================================================================
// tb_register_shift_reader
//
// Self-checking bench for register_shift_reader (WIDTH=16). A table of
// directed words (with stall and back-to-back options) is run first, then a
// reset-abort sequence, then a randomized phase checked against a queue model
// of the expected bit stream. Build with REGISTER_SHIFT_READER_PARITY_EN
// defined to exercise the parity variant.
// ============================================================================
module tb_register_shift_reader;

  localparam int WIDTH = 16;
`ifdef REGISTER_SHIFT_READER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  register_shift_reader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          stall_at;
    int          stall_len;
    bit          hold_next;
    logic [15:0] next_word;
    logic        exp_parity;
  } vec_t;

  vec_t vecs[6];

  // Even parity by counting ones.
  function automatic logic parity_of(input logic [15:0] w);
    int ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(w[i]);
    return logic'(ones % 2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Offers one word, then consumes up to max_bits bits, stalling for
  // stall_len cycles while bit stall_at is presented. Called and returns just
  // after a falling edge.
  task automatic applyStimulus(input logic [15:0] word, input int stall_at,
                               input int stall_len, input bit hold_next,
                               input logic [15:0] next_word,
                               input logic exp_parity, input int max_bits);
    int  w      = 0;
    int  idx    = 0;
    int  stalls = 0;
    int  cyc    = 0;
    logic exp_bit;
    in_word    = word;
    in_valid   = 1'b1;
    sout_ready = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w == 50) checkOutput("accept_timeout", 32'(w), 32'(0));
    @(negedge clk);
    cyc = 1;
    if (hold_next) in_word = next_word;
    else in_valid = 1'b0;
    while (idx < max_bits && cyc < 200) begin
      exp_bit = (idx < WIDTH) ? word[idx] : exp_parity;
      checkOutput($sformatf("sout_valid[%0d]", idx), 32'(sout_valid), 32'(1));
      checkOutput($sformatf("sout[%0d]", idx), 32'(sout), 32'(exp_bit));
      checkOutput($sformatf("sout_last[%0d]", idx), 32'(sout_last),
                  32'(idx == NB - 1));
      checkOutput($sformatf("busy[%0d]", idx), 32'(busy), 32'(1));
      checkOutput($sformatf("in_ready_busy[%0d]", idx), 32'(in_ready), 32'(0));
      if (idx == stall_at && stalls < stall_len) begin
        sout_ready = 1'b0;
        stalls++;
      end else begin
        sout_ready = 1'b1;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) checkOutput("bit_timeout", 32'(cyc), 32'(0));
    if (max_bits >= NB) begin
      checkOutput("done_cycle", 32'(cyc), 32'(NB + 1 + stall_len));
      checkOutput("done_in_ready", 32'(in_ready), 32'(1));
      checkOutput("done_busy", 32'(busy), 32'(0));
      checkOutput("done_sout_valid", 32'(sout_valid), 32'(0));
      checkOutput("done_sout_last", 32'(sout_last), 32'(0));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
    checkOutput({tag, "_sout_valid"}, 32'(sout_valid), 32'(0));
    checkOutput({tag, "_sout"}, 32'(sout), 32'(0));
    checkOutput({tag, "_sout_last"}, 32'(sout_last), 32'(0));
  endtask

  // Random phase: expected stream kept as a queue of bits; each accepted word
  // appends its bits, each observed transfer pops the head.
  task automatic randomPhase(input int cycles);
    logic exp_q[$];
    logic [15:0] w;
    for (int c = 0; c < cycles; c++) begin
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      checkOutput("rnd_sout_valid", 32'(sout_valid), 32'(exp_q.size() != 0));
      checkOutput("rnd_busy", 32'(busy), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        checkOutput("rnd_sout", 32'(sout), 32'(exp_q[0]));
        checkOutput("rnd_sout_last", 32'(sout_last), 32'(exp_q.size() == 1));
      end
      w          = 16'($urandom);
      in_word    = w;
      in_valid   = ($urandom % 2) == 0;
      sout_ready = ($urandom % 4) != 0;
      if (exp_q.size() == 0) begin
        if (in_valid) begin
          for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
          if (NB > WIDTH) exp_q.push_back(parity_of(w));
        end
      end else if (sout_ready) begin
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{16'hA5C3, -1, 0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'hA5C3,  5, 3, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{16'h0000, -1, 0, 1'b1, 16'hFFFF, 1'b0};
    vecs[3] = '{16'hFFFF, -1, 0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{16'h0007, -1, 0, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0003,  2, 1, 1'b0, 16'h0000, 1'b0};

    reset_n    = 1'b0;
    in_word    = '0;
    in_valid   = 1'b0;
    sout_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    for (int v = 0; v < 6; v++) begin
      checkOutput($sformatf("table_parity[%0d]", v),
                  32'(parity_of(vecs[v].word)), 32'(vecs[v].exp_parity));
      applyStimulus(vecs[v].word, vecs[v].stall_at, vecs[v].stall_len,
                    vecs[v].hold_next, vecs[v].next_word, vecs[v].exp_parity, NB);
    end

    // Abort 16'h1234 after seven bits; outputs must clear without a clock.
    applyStimulus(16'h1234, -1, 0, 1'b0, 16'h0000, 1'b1, 7);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    checkIdleOutputs("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0001, -1, 0, 1'b0, 16'h0000, 1'b1, NB);

    randomPhase(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
